// File: rtl/data_mem_pipe.sv
// Pipelined byte-lane data memory: valid/ready requests, init sweep after reset, fault flagging.
// Optional feature macro DATA_MEM_PIPE_FAULT_LATCH_EN adds sticky first-fault capture ports.
module data_mem_pipe #(
   parameter int          DEPTH     = 128,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          RD_LAT    = 1
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        ReqValid,
   output logic        ReqReady,
   input  logic [31:0] Address,
   input  logic        WE,
   input  logic [1:0]  Size,
   input  logic [31:0] WD,
   output logic        RspValid,
   output logic        RspWrite,
   output logic [31:0] ReadData,
   output logic        Fault,
   output logic        InitDone
`ifdef DATA_MEM_PIPE_FAULT_LATCH_EN
   ,
   input  logic        FaultClr,
   output logic        FaultSticky,
   output logic [31:0] FaultAddr
`endif
);
   localparam int IDX_W = $clog2(DEPTH);

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic [31:0]      mem [DEPTH];

   logic             acc;
   logic [29:0]      idx_full;
   logic [IDX_W-1:0] idx;
   logic [1:0]       lane;
   logic             req_flt;
   logic [31:0]      wmask, wsh, rd_word, rd_fmt;
   logic [15:0]      rd_sh;

   logic             vld_p   [RD_LAT];
   logic             wr_p    [RD_LAT];
   logic             flt_p   [RD_LAT];
   logic [31:0]      rdata_p [RD_LAT];

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= S_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ReqReady = 1'b0;
      InitDone = 1'b0;
      case (state_q)
         S_INIT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == IDX_W'(DEPTH - 1)) state_d = S_RUN;
         end
         default: begin
            ReqReady = 1'b1;
            InitDone = 1'b1;
         end
      endcase
   end

   // Request decode: upper address bits only feed the range check
   assign acc      = ReqValid && ReqReady;
   assign idx_full = 30'((Address - BASE_ADDR) >> 2);
   assign idx      = idx_full[IDX_W-1:0];
   assign lane     = Address[1:0];

   always_comb begin
      req_flt = (Address < BASE_ADDR) || (idx_full >= 30'(DEPTH));
      wmask   = '0;
      wsh     = '0;
      case (Size)
         2'b00: begin
            wmask = 32'h0000_00FF << {lane, 3'b000};
            wsh   = {24'b0, WD[7:0]} << {lane, 3'b000};
         end
         2'b01: begin
            req_flt = req_flt || lane[0];
            wmask   = 32'h0000_FFFF << {lane, 3'b000};
            wsh     = {16'b0, WD[15:0]} << {lane, 3'b000};
         end
         2'b10: begin
            req_flt = req_flt || (lane != 2'b00);
            wmask   = '1;
            wsh     = WD;
         end
         default: req_flt = 1'b1;
      endcase
   end

   always_comb begin
      rd_word = mem[idx];
      rd_sh   = 16'(rd_word >> {lane, 3'b000});
      case (Size)
         2'b00:   rd_fmt = {24'b0, rd_sh[7:0]};
         2'b01:   rd_fmt = {16'b0, rd_sh};
         default: rd_fmt = rd_word;
      endcase
      if (WE || req_flt) rd_fmt = '0;
   end

   // Array write: init sweep has priority, stores commit at the accepting edge
   always_ff @(posedge CLK) begin
      if (state_q == S_INIT)
         mem[cnt_q] <= '0;
      else if (acc && WE && !req_flt)
         mem[idx] <= (rd_word & ~wmask) | (wsh & wmask);
   end

   // Stage p0 captures the response at acceptance; later stages only delay it
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < RD_LAT; i++) begin
            vld_p[i] <= 1'b0;
            wr_p[i]  <= 1'b0;
            flt_p[i] <= 1'b0;
         end
      end else begin
         vld_p[0] <= acc;
         wr_p[0]  <= acc && WE;
         flt_p[0] <= acc && req_flt;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_p[i] <= vld_p[i-1];
            wr_p[i]  <= wr_p[i-1];
            flt_p[i] <= flt_p[i-1];
         end
      end
   end

   always_ff @(posedge CLK) begin
      rdata_p[0] <= rd_fmt;
      for (int i = 1; i < RD_LAT; i++) rdata_p[i] <= rdata_p[i-1];
   end

   assign RspValid = vld_p[RD_LAT-1];
   assign RspWrite = vld_p[RD_LAT-1] && wr_p[RD_LAT-1];
   assign Fault    = vld_p[RD_LAT-1] && flt_p[RD_LAT-1];
   assign ReadData = vld_p[RD_LAT-1] ? rdata_p[RD_LAT-1] : '0;

`ifdef DATA_MEM_PIPE_FAULT_LATCH_EN
   logic [31:0] addr_p [RD_LAT];

   always_ff @(posedge CLK) begin
      addr_p[0] <= Address;
      for (int i = 1; i < RD_LAT; i++) addr_p[i] <= addr_p[i-1];
   end

   // A fault arriving with a clear re-arms the capture with the new address
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         FaultSticky <= 1'b0;
         FaultAddr   <= '0;
      end else if (Fault && (!FaultSticky || FaultClr)) begin
         FaultSticky <= 1'b1;
         FaultAddr   <= addr_p[RD_LAT-1];
      end else if (FaultClr) begin
         FaultSticky <= 1'b0;
         FaultAddr   <= '0;
      end
   end
`endif

endmodule
